// File: rtl/comp_vote_ctrl.sv
// Comparator voting controller: clocks NCOMP comparator slices, accumulates positive/negative
// votes over one or more comparisons and reports a registered decision with timeout flags.
module comp_vote_ctrl #(
   parameter int unsigned NCOMP = 4,
   parameter int unsigned TMO   = 15,
   parameter int unsigned DLY   = 1,
   localparam int unsigned CW   = $clog2(NCOMP * 15 + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             startlsb_i,
   input  logic [3:0]       reps_i,
   input  logic             done_i,
   input  logic [NCOMP-1:0] vop_i,
   input  logic [NCOMP-1:0] von_i,
   output logic             ckc_o,
   output logic             busy_o,
   output logic             dec_o,
   output logic             dec_vld_o,
   output logic             tie_o,
   output logic             meta_o,
   output logic [CW-1:0]    pcnt_o,
   output logic [CW-1:0]    ncnt_o
);

   typedef enum logic [1:0] {StIdle, StEval, StRecover, StDecide} state_e;

   state_e           state_q, state_d;
   logic [NCOMP-1:0] vop_s1_q, vop_s2_q, von_s1_q, von_s2_q;
   logic [3:0]       cnt_q, cnt_d, rep_q, rep_d, tgt_q, tgt_d;
   logic [CW-1:0]    pcnt_q, pcnt_d, ncnt_q, ncnt_d, pos_add, neg_add;
   logic             meta_q, meta_d, dec_q, dec_d, tie_q, tie_d;
   logic             dec_vld_q, dec_vld_d, ckc_q, ckc_d, busy_q, busy_d;
   logic             all_valid, any_high, both_hi, tmo_hit, dly_met;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vop_s1_q <= '0;
         vop_s2_q <= '0;
         von_s1_q <= '0;
         von_s2_q <= '0;
      end else begin
         vop_s1_q <= vop_i;
         vop_s2_q <= vop_s1_q;
         von_s1_q <= von_i;
         von_s2_q <= von_s1_q;
      end
   end

   // A slice with both outputs high is treated as invalid: it votes for neither side.
   always_comb begin
      pos_add = '0;
      neg_add = '0;
      for (int i = 0; i < int'(NCOMP); i++) begin
         pos_add = pos_add + CW'(vop_s2_q[i] & ~von_s2_q[i]);
         neg_add = neg_add + CW'(von_s2_q[i] & ~vop_s2_q[i]);
      end
   end

   assign all_valid = &(vop_s2_q | von_s2_q);
   assign any_high  = |(vop_s2_q | von_s2_q);
   assign both_hi   = |(vop_s2_q & von_s2_q);
   // cnt_q counts cycles already spent in the state; +1 includes the current one.
   assign tmo_hit   = ({1'b0, cnt_q} + 5'd1) >= 5'(TMO);
   assign dly_met   = ({1'b0, cnt_q} + 5'd1) >= 5'(DLY);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rep_q     <= '0;
         tgt_q     <= '0;
         pcnt_q    <= '0;
         ncnt_q    <= '0;
         meta_q    <= 1'b0;
         dec_q     <= 1'b0;
         tie_q     <= 1'b0;
         dec_vld_q <= 1'b0;
         ckc_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rep_q     <= rep_d;
         tgt_q     <= tgt_d;
         pcnt_q    <= pcnt_d;
         ncnt_q    <= ncnt_d;
         meta_q    <= meta_d;
         dec_q     <= dec_d;
         tie_q     <= tie_d;
         dec_vld_q <= dec_vld_d;
         ckc_q     <= ckc_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 4'd1;
      rep_d   = rep_q;
      tgt_d   = tgt_q;
      pcnt_d  = pcnt_q;
      ncnt_d  = ncnt_q;
      meta_d  = meta_q;
      if (done_i) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (start_i) begin
                  state_d = StEval;
                  tgt_d   = (startlsb_i && reps_i != 4'd0) ? reps_i : 4'd1;
                  rep_d   = '0;
                  pcnt_d  = '0;
                  ncnt_d  = '0;
                  meta_d  = 1'b0;
               end
            end
            StEval: begin
               if (all_valid || tmo_hit) begin
                  state_d = StRecover;
                  cnt_d   = '0;
                  rep_d   = rep_q + 4'd1;
                  pcnt_d  = pcnt_q + pos_add;
                  ncnt_d  = ncnt_q + neg_add;
                  if (!all_valid || both_hi) meta_d = 1'b1;
               end
            end
            StRecover: begin
               if (dly_met && !any_high) begin
                  cnt_d   = '0;
                  state_d = (rep_q < tgt_q) ? StEval : StDecide;
               end else if (tmo_hit) begin
                  cnt_d   = '0;
                  meta_d  = 1'b1;
                  state_d = StDecide;
               end
            end
            StDecide: begin
               cnt_d   = '0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      ckc_d     = (state_d == StEval);
      busy_d    = (state_d != StIdle);
      dec_vld_d = (state_q == StDecide) && !done_i;
      dec_d     = dec_q;
      tie_d     = tie_q;
      if (state_q == StIdle && start_i && !done_i) begin
         dec_d = 1'b0;
         tie_d = 1'b0;
      end
      if (dec_vld_d) begin
         dec_d = (pcnt_q > ncnt_q);
         tie_d = (pcnt_q == ncnt_q);
      end
   end

   assign ckc_o     = ckc_q;
   assign busy_o    = busy_q;
   assign dec_o     = dec_q;
   assign dec_vld_o = dec_vld_q;
   assign tie_o     = tie_q;
   assign meta_o    = meta_q;
   assign pcnt_o    = pcnt_q;
   assign ncnt_o    = ncnt_q;

endmodule

// File: tb/tb_comp_vote_ctrl.sv
// Bench for comp_vote_ctrl: table of conversion steps against an ideal comparator model,
// plus hand-written abort and reset sequences.
module tb_comp_vote_ctrl;

   localparam int unsigned NCOMP = 4;
   localparam int unsigned CW    = $clog2(NCOMP * 15 + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, startlsb, done;
   logic [3:0]       reps;
   logic [NCOMP-1:0] cmp_p, cmp_n, vop, von;
   logic             ckc, busy, dec, dec_vld, tie, meta;
   logic [CW-1:0]    pcnt, ncnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Ideal comparators: resolve instantly while clocked, precharge low otherwise.
   assign vop = ckc ? cmp_p : '0;
   assign von = ckc ? cmp_n : '0;

   comp_vote_ctrl #(.NCOMP(NCOMP), .TMO(15), .DLY(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .startlsb_i(startlsb), .reps_i(reps),
      .done_i(done), .vop_i(vop), .von_i(von), .ckc_o(ckc), .busy_o(busy), .dec_o(dec),
      .dec_vld_o(dec_vld), .tie_o(tie), .meta_o(meta), .pcnt_o(pcnt), .ncnt_o(ncnt)
   );

   typedef struct {
      logic       lsb;
      logic [3:0] reps;
      logic [3:0] p;
      logic [3:0] n;
      int         lat;
      int         ckc_cyc;
      logic       dec;
      logic       tie;
      logic       meta;
      int         pc;
      int         nc;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic launch(input logic lsb, input logic [3:0] r, input logic [3:0] p,
                         input logic [3:0] n);
      cmp_p = p;
      cmp_n = n;
      @(negedge clk);
      start    = 1'b1;
      startlsb = lsb;
      reps     = r;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int edges, ckc_cnt;
      bit got;
      launch(v.lsb, v.reps, v.p, v.n);
      check($sformatf("v%0d busy", idx), int'(busy), 1);
      edges   = 0;
      ckc_cnt = int'(ckc);
      got     = 0;
      while (!got && edges < 300) begin
         @(posedge clk);
         #1 edges++;
         if (dec_vld) got = 1;
         else ckc_cnt += int'(ckc);
      end
      check($sformatf("v%0d dec_vld_seen", idx), int'(got), 1);
      check($sformatf("v%0d latency", idx), edges, v.lat);
      check($sformatf("v%0d ckc_cycles", idx), ckc_cnt, v.ckc_cyc);
      check($sformatf("v%0d dec", idx), int'(dec), int'(v.dec));
      check($sformatf("v%0d tie", idx), int'(tie), int'(v.tie));
      check($sformatf("v%0d meta", idx), int'(meta), int'(v.meta));
      check($sformatf("v%0d pcnt", idx), int'(pcnt), v.pc);
      check($sformatf("v%0d ncnt", idx), int'(ncnt), v.nc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d pulse_end", idx), int'(dec_vld), 0);
      check($sformatf("v%0d hold_pcnt", idx), int'(pcnt), v.pc);
      check($sformatf("v%0d hold_dec", idx), int'(dec), int'(v.dec));
   endtask

   initial begin
      int vld_seen, busy_seen;
      //          lsb  reps   p        n        lat ckc dec  tie  meta pc  nc
      vecs[0] = '{1'b0, 4'd0, 4'b1111, 4'b0000, 7,  3,  1'b1, 1'b0, 1'b0, 4,  0};
      vecs[1] = '{1'b1, 4'd3, 4'b0111, 4'b1000, 19, 9,  1'b1, 1'b0, 1'b0, 9,  3};
      vecs[2] = '{1'b1, 4'd2, 4'b0011, 4'b1100, 13, 6,  1'b0, 1'b1, 1'b0, 4,  4};
      vecs[3] = '{1'b0, 4'd0, 4'b1011, 4'b0000, 19, 15, 1'b1, 1'b0, 1'b1, 3,  0};
      vecs[4] = '{1'b0, 4'd0, 4'b1111, 4'b0001, 7,  3,  1'b1, 1'b0, 1'b1, 3,  0};
      vecs[5] = '{1'b1, 4'd0, 4'b0000, 4'b1111, 7,  3,  1'b0, 1'b0, 1'b0, 0,  4};
      vecs[6] = '{1'b0, 4'd5, 4'b0001, 4'b1110, 7,  3,  1'b0, 1'b0, 1'b0, 1,  3};
      vecs[7] = '{1'b1, 4'd15, 4'b1111, 4'b0000, 91, 45, 1'b1, 1'b0, 1'b0, 60, 0};
      vecs[8] = '{1'b0, 4'd0, 4'b0000, 4'b0000, 17, 15, 1'b0, 1'b1, 1'b1, 0,  0};

      rst_n = 1'b0; start = 1'b0; startlsb = 1'b0; reps = '0; done = 1'b0;
      cmp_p = '0; cmp_n = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst ckc", int'(ckc), 0);
      check("rst busy", int'(busy), 0);
      check("rst dec_vld", int'(dec_vld), 0);
      check("rst meta", int'(meta), 0);
      check("rst pcnt", int'(pcnt), 0);
      check("rst ncnt", int'(ncnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Abort in the second comparison of a 3-rep step, with START offered the same cycle.
      launch(1'b1, 4'd3, 4'b1111, 4'b0000);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      check("abort in_eval2 ckc", int'(ckc), 1);
      done  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("abort ckc", int'(ckc), 0);
      check("abort busy", int'(busy), 0);
      check("abort pcnt", int'(pcnt), 4);
      done  = 1'b0;
      start = 1'b0;
      vld_seen  = 0;
      busy_seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         vld_seen  += int'(dec_vld);
         busy_seen += int'(busy);
      end
      check("abort no_dec_vld", vld_seen, 0);
      check("abort stays_idle", busy_seen, 0);
      check("abort hold_pcnt", int'(pcnt), 4);

      // DONE beats START in IDLE.
      @(negedge clk);
      done  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("done_vs_start busy", int'(busy), 0);
      done  = 1'b0;
      start = 1'b0;

      // Reset during RECOVER, then during EVAL.
      launch(1'b0, 4'd0, 4'b1111, 4'b0000);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("rec pcnt_before", int'(pcnt), 4);
      rst_n = 1'b0;
      #1;
      check("rec_rst busy", int'(busy), 0);
      check("rec_rst pcnt", int'(pcnt), 0);
      check("rec_rst dec", int'(dec), 0);
      @(negedge clk);
      rst_n = 1'b1;
      launch(1'b0, 4'd0, 4'b1111, 4'b0000);
      @(posedge clk);
      #1;
      check("eval ckc_before", int'(ckc), 1);
      rst_n = 1'b0;
      #1;
      check("eval_rst ckc", int'(ckc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      busy_seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         busy_seen += int'(busy);
      end
      check("post_rst idle", busy_seen, 0);
      run_vec(9, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/comp_vote_ctrl.md
COMP_VOTE_CTRL -- requirements
Module: comp_vote_ctrl

Interface
REQ-001 Parameter NCOMP, 4: number of parallel comparator slices, 1..8.
REQ-002 Parameter TMO, 15: maximum EVAL or RECOVER cycles before timeout; SHALL be >= 3, 4-bit counter.
REQ-003 Parameter DLY, 1: minimum RECOVER (precharge) cycles per comparison, 1..7.
REQ-004 Port CLK  in  1  single clock; all state on rising edge.
REQ-005 Port RSTN  in  1  reset, asynchronous, active-low.
REQ-006 Port START  in  1  request one conversion step; sampled only in IDLE.
REQ-007 Port STARTLSB  in  1  sampled with START; 1 = voting mode (REPS comparisons), 0 = single comparison.
REQ-008 Port REPS  in  4  comparisons in voting mode, sampled with START; 0 treated as 1.
REQ-009 Port DONE  in  1  abort; forces return to IDLE.
REQ-010 Port VOP, VON  in  NCOMP each  asynchronous comparator outputs, one bit per slice.
REQ-011 Port CKC  out  1  comparator clock: 1 = evaluate, 0 = precharge.
REQ-012 Port BUSY  out  1  high in every state except IDLE.
REQ-013 Port DEC  out  1  final decision; 1 = positive.
REQ-014 Port DEC_VLD  out  1  one-cycle pulse; DEC, TIE, META, PCNT, NCNT valid.
REQ-015 Port TIE  out  1  PCNT equals NCNT.
REQ-016 Port META  out  1  a timeout occurred during this step.
REQ-017 Port PCNT, NCNT  out  CW  accumulated positive/negative slice votes, CW = clog2(NCOMP*15+1).

Function
REQ-018 VOP and VON SHALL each pass through a 2-flop synchronizer before any use; slice valid = syncVOP | syncVON.
REQ-019 FSM states SHALL be IDLE, EVAL, RECOVER and DECIDE; all outputs SHALL be registered.
REQ-020 IDLE -> EVAL on START=1 with DONE=0; latch mode and rep target; clear counts, META and rep counter.
REQ-021 EVAL: CKC=1; exit to RECOVER on the edge where all NCOMP synced slices are valid, or when the EVAL cycle counter reaches TMO.
REQ-022 On EVAL exit, each slice SHALL add to PCNT if syncVOP=1, else to NCNT if syncVON=1. Invalid (timed-out) slices add nothing. A timeout SHALL set META.
REQ-023 If syncVOP and syncVON are both 1 on a slice, that slice SHALL count as invalid and SHALL set META.
REQ-024 RECOVER: CKC=0; exit after at least DLY cycles and all synced VOP/VON low, or at TMO cycles with META set.
REQ-025 RECOVER exit -> EVAL if reps done < target and no RECOVER timeout; otherwise -> DECIDE.
REQ-026 DECIDE lasts 1 cycle: DEC_VLD=1, DEC = (PCNT > NCNT), TIE = (PCNT == NCNT) with DEC=0, then -> IDLE.
REQ-027 DEC, TIE, META, PCNT and NCNT SHALL hold until the next START is accepted.
REQ-028 DONE=1 in any state SHALL go to IDLE on the next edge: CKC=0, no DEC_VLD, counts held. DONE wins over a simultaneous START.
REQ-029 START outside IDLE SHALL be ignored; START is not queued.
REQ-030 Timing with instantly resolving comparators and DLY=1: EVAL = 3 cycles, RECOVER = 3 cycles, DEC_VLD high after edge 6N+1 following the START-sampling edge (N = comparisons).

Reset
REQ-031 RSTN=0 SHALL asynchronously force IDLE and clear the synchronizers, counters, CKC, BUSY, DEC, DEC_VLD, TIE, META, PCNT and NCNT to 0.
REQ-032 Reset mid-operation SHALL drop CKC at once. After RSTN release, the block SHALL wait for a new START.

Verification
REQ-033 NCOMP=4, STARTLSB=0, all slices resolve VOP=1 instantly -> CKC high edges 1-3, DEC_VLD after edge 7, DEC=1, PCNT=4, NCNT=0, META=0.
REQ-034 STARTLSB=1, REPS=3, slices split 3P/1N each rep -> 3 CKC pulses, DEC_VLD after edge 19, PCNT=9, NCNT=3, DEC=1.
REQ-035 REPS=2, 2P/2N each rep -> PCNT=4, NCNT=4, TIE=1, DEC=0.
REQ-036 Slice 2 never resolves, TMO=15 -> EVAL exits after 15 cycles, META=1, slice 2 contributes 0 votes.
REQ-037 DONE asserted in second EVAL of a 3-rep step -> CKC=0 and IDLE next edge, no DEC_VLD; START the same cycle ignored.
REQ-038 RSTN pulsed low during RECOVER -> all outputs 0 immediately; the next START runs a full normal step.
